// File: rtl/td4_pkg.sv
// Shared types and opcode map for the 4-bit TD4-class core.
// Consumed by the decoder, the core and its bus interface.
package td4_pkg;

  typedef logic [3:0] word_t;
  typedef logic [7:0] instr_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } alu_src_e;

  typedef struct packed {
    logic     we_a;
    logic     we_b;
    logic     we_out;
    logic     ld_pc;
    alu_src_e src;
    logic     use_im;
    logic     c_add;
  } ctrl_t;

endpackage

// File: rtl/cpu_if.sv
// ROM / board-side port bundle of the core: program address, instruction,
// input switches and output LEDs.
interface cpu_if;
  import td4_pkg::*;

  word_t  address;
  instr_t instr;
  word_t  in;
  word_t  out;

  modport master (output address, output out, input instr, input in);
  modport slave  (input address, input out, output instr, output in);
endinterface

// File: rtl/cpu_decode.sv
// Combinational decode of opcode and carry into write enables, ALU source
// select, immediate gating and carry-write select.
module cpu_decode
  import td4_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_c,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.src    = SRC_ZERO;
    case (i_opcode)
      OP_ADD_A:  begin o_ctrl.we_a = 1'b1; o_ctrl.src = SRC_A; o_ctrl.use_im = 1'b1; o_ctrl.c_add = 1'b1; end
      OP_MOV_AB: begin o_ctrl.we_a = 1'b1; o_ctrl.src = SRC_B; end
      OP_IN_A:   begin o_ctrl.we_a = 1'b1; o_ctrl.src = SRC_IN; end
      OP_MOV_A:  begin o_ctrl.we_a = 1'b1; o_ctrl.use_im = 1'b1; end
      OP_MOV_BA: begin o_ctrl.we_b = 1'b1; o_ctrl.src = SRC_A; end
      OP_ADD_B:  begin o_ctrl.we_b = 1'b1; o_ctrl.src = SRC_B; o_ctrl.use_im = 1'b1; o_ctrl.c_add = 1'b1; end
      OP_IN_B:   begin o_ctrl.we_b = 1'b1; o_ctrl.src = SRC_IN; end
      OP_MOV_B:  begin o_ctrl.we_b = 1'b1; o_ctrl.use_im = 1'b1; end
      OP_OUT_B:  begin o_ctrl.we_out = 1'b1; o_ctrl.src = SRC_B; end
      OP_OUT_IM: begin o_ctrl.we_out = 1'b1; o_ctrl.use_im = 1'b1; end
      // JNC sees the carry left by the previous instruction only
      OP_JNC:    begin o_ctrl.ld_pc = ~i_c; o_ctrl.use_im = 1'b1; end
      OP_JMP:    begin o_ctrl.ld_pc = 1'b1; o_ctrl.use_im = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle 4-bit core: registers, shared adder (also used as the move
// path) and PC incrementer; one instruction retires per rising edge.
module cpu
  import td4_pkg::*;
(
  input  logic     clk,
  input  logic     n_reset,
  cpu_if.master    bus
);

  word_t r_a, r_b, r_out, r_pc;
  logic  r_c;

  ctrl_t      w_ctrl;
  word_t      w_src;
  word_t      w_im;
  logic [4:0] w_sum;

  cpu_decode u_decode (
    .i_opcode (bus.instr[7:4]),
    .i_c      (r_c),
    .o_ctrl   (w_ctrl)
  );

  always_comb begin
    w_src = '0;
    case (w_ctrl.src)
      SRC_A:   w_src = r_a;
      SRC_B:   w_src = r_b;
      SRC_IN:  w_src = bus.in;
      default: w_src = '0;
    endcase
  end

  // Moves pass through the adder with a zero operand, so every write uses w_sum
  assign w_im  = w_ctrl.use_im ? bus.instr[3:0] : 4'd0;
  assign w_sum = {1'b0, w_src} + {1'b0, w_im};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_out <= '0;
      r_pc  <= '0;
      r_c   <= 1'b0;
    end else begin
      if (w_ctrl.we_a)   r_a   <= w_sum[3:0];
      if (w_ctrl.we_b)   r_b   <= w_sum[3:0];
      if (w_ctrl.we_out) r_out <= w_sum[3:0];
      r_c  <= w_ctrl.c_add & w_sum[4];
      r_pc <= w_ctrl.ld_pc ? w_sum[3:0] : r_pc + 4'd1;
    end
  end

  assign bus.address = r_pc;
  assign bus.out     = r_out;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: combinational ROM model, one task per feature.
module tb_cpu;
  import td4_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] rom [16];
  int         total = 0;
  int         bad = 0;

  cpu_if bus();

  cpu dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  assign bus.instr = rom[bus.address];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    #1;
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    fill_rom(8'hB5);
    bus.in = 4'h9;
    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.address !== 4'd0 || bus.out !== 4'd0) begin
        bad++;
        $display("FAIL reset_hold: address=%h out=%h want 0 0", bus.address, bus.out);
      end
    end
    n_reset = 1'b1;
    step();
    step();
    total++;
    if (bus.address !== 4'd2 || bus.out !== 4'h5) begin
      bad++;
      $display("FAIL reset_run: address=%h out=%h want 2 5", bus.address, bus.out);
    end
    #2;
    n_reset = 1'b0;
    #1;
    total++;
    if (bus.address !== 4'd0 || bus.out !== 4'd0) begin
      bad++;
      $display("FAIL reset_async: address=%h out=%h want 0 0", bus.address, bus.out);
    end
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_carry_jnc();
    // ADD A overflow: JNC falls through, A observed as 0 through B
    fill_rom(8'h80);
    rom[0] = 8'hBF; rom[1] = 8'h3F; rom[2] = 8'h01; rom[3] = 8'hE0;
    rom[4] = 8'h40; rom[5] = 8'h90;
    do_reset();
    repeat (3) step();
    total++;
    if (bus.address !== 4'd3) begin
      bad++;
      $display("FAIL carry_pre_jnc: address=%h want 3", bus.address);
    end
    step();
    total++;
    if (bus.address !== 4'd4) begin
      bad++;
      $display("FAIL jnc_not_taken: address=%h want 4", bus.address);
    end
    step();
    step();
    total++;
    if (bus.out !== 4'h0) begin
      bad++;
      $display("FAIL add_wrap_a: out=%h want 0", bus.out);
    end
    // No carry: JNC taken back to 0
    rom[1] = 8'h3E;
    do_reset();
    repeat (4) step();
    total++;
    if (bus.address !== 4'd0) begin
      bad++;
      $display("FAIL jnc_taken: address=%h want 0", bus.address);
    end
    // NOP between ADD and JNC clears C, so JNC is taken
    fill_rom(8'h80);
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h80; rom[3] = 8'hE9;
    do_reset();
    repeat (4) step();
    total++;
    if (bus.address !== 4'd9) begin
      bad++;
      $display("FAIL nop_clears_c: address=%h want 9", bus.address);
    end
    // ADD B overflow: F+2 = 1 with carry
    fill_rom(8'h80);
    rom[0] = 8'h7F; rom[1] = 8'h52; rom[2] = 8'hEA; rom[3] = 8'h90;
    do_reset();
    repeat (3) step();
    total++;
    if (bus.address !== 4'd3) begin
      bad++;
      $display("FAIL add_b_carry: address=%h want 3", bus.address);
    end
    step();
    total++;
    if (bus.out !== 4'h1) begin
      bad++;
      $display("FAIL add_b_sum: out=%h want 1", bus.out);
    end
  endtask

  task automatic test_io();
    fill_rom(8'h80);
    rom[0]  = 8'h60; rom[1]  = 8'h90; rom[2]  = 8'h35; rom[3]  = 8'h40;
    rom[4]  = 8'h90; rom[5]  = 8'hB7; rom[6]  = 8'h20; rom[7]  = 8'h40;
    rom[8]  = 8'h90; rom[9]  = 8'h7C; rom[10] = 8'h10; rom[11] = 8'h79;
    rom[12] = 8'h40; rom[13] = 8'h90;
    bus.in = 4'hA;
    do_reset();
    step();
    bus.in = 4'h0;
    step();
    total++;
    if (bus.out !== 4'hA) begin
      bad++;
      $display("FAIL in_b_out_b: out=%h want a", bus.out);
    end
    step();
    total++;
    if (bus.out !== 4'hA) begin
      bad++;
      $display("FAIL out_hold: out=%h want a", bus.out);
    end
    step();
    step();
    total++;
    if (bus.out !== 4'h5) begin
      bad++;
      $display("FAIL mov_ba_out: out=%h want 5", bus.out);
    end
    step();
    total++;
    if (bus.out !== 4'h7) begin
      bad++;
      $display("FAIL out_im: out=%h want 7", bus.out);
    end
    bus.in = 4'h3;
    step();
    bus.in = 4'hF;
    step();
    step();
    total++;
    if (bus.out !== 4'h3) begin
      bad++;
      $display("FAIL in_a: out=%h want 3", bus.out);
    end
    repeat (5) step();
    total++;
    if (bus.out !== 4'hC) begin
      bad++;
      $display("FAIL mov_ab: out=%h want c", bus.out);
    end
  endtask

  task automatic test_jmp_hold();
    fill_rom(8'h80);
    rom[0]  = 8'hB9;
    rom[15] = 8'hFF;
    do_reset();
    repeat (15) step();
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.address !== 4'd15 || bus.out !== 4'h9) begin
        bad++;
        $display("FAIL jmp_hold[%0d]: address=%h out=%h want f 9", i, bus.address, bus.out);
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [3:0] nops [4];
    nops[0] = 4'b1000; nops[1] = 4'b1010; nops[2] = 4'b1100; nops[3] = 4'b1101;
    for (int i = 0; i < 16; i++) rom[i] = {nops[i % 4], 4'hF};
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step();
      total++;
      if (bus.address !== 4'(i % 16)) begin
        bad++;
        $display("FAIL pc_wrap[%0d]: address=%h want %h", i, bus.address, 4'(i % 16));
      end
    end
    total++;
    if (bus.out !== 4'h0) begin
      bad++;
      $display("FAIL nop_no_out: out=%h want 0", bus.out);
    end
  endtask

  task automatic test_timer();
    logic [3:0] seen [$];
    logic [3:0] exp [35];
    logic [3:0] prev;
    exp[0] = 4'h7;
    exp[1] = 4'h6;
    for (int k = 0; k < 16; k++) begin
      exp[2 + 2*k] = 4'h0;
      exp[3 + 2*k] = 4'h4;
    end
    exp[34] = 4'h8;
    rom[0]  = 8'hB7; rom[1]  = 8'h01; rom[2]  = 8'hE1; rom[3]  = 8'h01;
    rom[4]  = 8'hE3; rom[5]  = 8'hB6; rom[6]  = 8'h01; rom[7]  = 8'hE6;
    rom[8]  = 8'h01; rom[9]  = 8'hE8; rom[10] = 8'hB0; rom[11] = 8'hB4;
    rom[12] = 8'h01; rom[13] = 8'hEA; rom[14] = 8'hB8; rom[15] = 8'hFF;
    bus.in = 4'h0;
    do_reset();
    prev = 4'h0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (bus.out !== prev && seen.size() < 40) seen.push_back(bus.out);
      prev = bus.out;
    end
    total++;
    if (seen.size() != 35) begin
      bad++;
      $display("FAIL timer_count: changes=%0d want 35", seen.size());
    end
    for (int i = 0; i < 35; i++) begin
      total++;
      if (i >= seen.size()) begin
        bad++;
        $display("FAIL timer_seq[%0d]: missing want %h", i, exp[i]);
      end else if (seen[i] !== exp[i]) begin
        bad++;
        $display("FAIL timer_seq[%0d]: out=%h want %h", i, seen[i], exp[i]);
      end
    end
    total++;
    if (bus.address !== 4'd15) begin
      bad++;
      $display("FAIL timer_end: address=%h want f", bus.address);
    end
  endtask

  initial begin
    bus.in = 4'h0;
    fill_rom(8'h80);
    #1;
    test_reset();
    test_carry_jnc();
    test_io();
    test_jmp_hold();
    test_pc_wrap();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Four-bit single-cycle TD4-class processor core. Fetches one 8-bit instruction per clock from an external asynchronous program ROM, executes it, and drives a 4-bit output port from an internal output register. Sits between the board top level, which supplies the clock, reset button, input switches and program ROM, and the LEDs it drives.

## Interface
- No parameters. Data width is fixed at 4 bits, instruction width at 8 bits, and program space at 16 words.
- clk  input  1  single clock; all state updates on the rising edge
- n_reset  input  1  asynchronous, active-low reset
- address  output  4  program counter, drives the ROM address
- instr  input  8  instruction from ROM for the current address (combinational)
- in  input  4  input port, sampled at the clock edge by IN instructions
- out  output  4  output port, driven directly by the OUT register

## Operation
- State: A[3:0], B[3:0], OUT[3:0], PC[3:0], C (carry flag, 1 bit).
- address = PC at all times.
- Instruction format: opcode = instr[7:4], Im = instr[3:0].
- Opcodes (one instruction per clock):
  - 0000 ADD A,Im: {C,A} ← A+Im
  - 0001 MOV A,B: A ← B
  - 0010 IN A: A ← in
  - 0011 MOV A,Im: A ← Im
  - 0100 MOV B,A: B ← A
  - 0101 ADD B,Im: {C,B} ← B+Im
  - 0110 IN B: B ← in
  - 0111 MOV B,Im: B ← Im
  - 1001 OUT B: OUT ← B
  - 1011 OUT Im: OUT ← Im
  - 1110 JNC Im: PC ← Im if C==0, else PC+1
  - 1111 JMP Im: PC ← Im
  - 1000, 1010, 1100, 1101: NOP (PC+1)
- Arithmetic: 4-bit unsigned add; C is bit 4 of the 5-bit sum. The incoming C does not feed the add.
- C is written on every instruction. ADD writes the carry-out; every other instruction, including JNC, JMP and NOP, writes C ← 0. JNC therefore tests the C produced by the immediately preceding instruction.
- PC ← PC+1 (mod 16) for all non-taken or non-jump instructions. The increment wraps from 15 to 0.
- Each instruction writes only its destination register plus C and PC. All other registers hold their values.

## Timing
- Single-cycle execution: decode is combinational from instr. All registers update on the same rising edge of clk.
- out reflects the new OUT value immediately after the edge of an OUT instruction; there is no extra pipeline delay.
- in is sampled only at the edge that executes IN A or IN B. No synchronizer is included; the top level owns metastability handling.
- Reset: when n_reset=0, A, B, OUT, PC and C are cleared to 0 immediately, without a clock. As a result, address=0 and out=0. Reset applies mid-instruction with no partial writes. The first instruction executes at the first rising edge after n_reset returns to 1.
- No handshakes. The ROM must present instr for the current address within one clock period.

## Structure
- Package td4_pkg:
  - opcode localparams (OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A, OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B, OP_OUT_B, OP_OUT_IM, OP_JNC, OP_JMP)
  - typedef for the 4-bit word
- One sub-module, cpu_decode: combinational. Maps opcode and C to:
  - register-write enables (A, B, OUT, PC-load)
  - ALU source select (A, B, in, zero)
  - carry-write value
- The cpu module holds the registers, the 4-bit adder and the PC incrementer.

## Test plan
- Reset: hold n_reset=0 with arbitrary instr and in, then toggle clk → address=0 and out=0 throughout. Pulse n_reset low mid-program with no clock edge → address and out return to 0 immediately.
- Carry and JNC: MOV A,0xF; ADD A,1; JNC 0 → after ADD, A=0 and C=1. JNC is not taken, so address=3. Repeat with MOV A,0xE: JNC is taken and address=0.
- Input and output: in=0xA; IN B; OUT B → out=0xA one edge after OUT B. Then MOV A,0x5; MOV B,A; OUT B → out=0x5. Then OUT Im 0x7 → out=0x7.
- JMP hold: JMP 0xF placed at address 15 → address stays 15 for 10 clocks and out is unchanged.
- PC wrap: 16 NOP or ADD instructions from reset → address sequence 0..15, then 0.
- Timer program:
  - Program:
    - addr 0: OUT 0111
    - addr 1-4: ADD A,1 / JNC loops
    - addr 5: OUT 0110
    - addr 6-9: two more loops
    - addr 10-13: blink loop
    - addr 14: OUT 1000
    - addr 15: JMP 15
  - Required response: out is 0111, then 0110, then sixteen 0000/0100 alternations, then 1000. address then holds at 15.
